// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC3 memory port: word RAM plus memory-mapped
// keyboard (input FIFO) and display (output holding register) devices.
module lc3_mem_responder #(
    parameter int          ADDR_W    = 8,
    parameter int          KB_DEPTH  = 4,
    parameter logic [15:0] KBSR_ADDR = 16'hFE00,
    parameter logic [15:0] KBDR_ADDR = 16'hFE02,
    parameter logic [15:0] DSR_ADDR  = 16'hFE04,
    parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mar,
    input  logic [15:0] mdr,
    input  logic        memwe,
    output logic [15:0] memOut,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        disp_overrun
);

    localparam int                PTR_W   = $clog2(KB_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam int                RAM_D   = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0]  KB_FULL = CNT_W'(KB_DEPTH);

    logic [15:0]      r_ram [RAM_D];
    logic [7:0]       r_kb_fifo [KB_DEPTH];
    logic [PTR_W-1:0] r_kb_rd_ptr;
    logic [PTR_W-1:0] r_kb_wr_ptr;
    logic [CNT_W-1:0] r_kb_count;
    logic             r_kbdr_q;
    logic             r_disp_valid;
    logic [7:0]       r_disp_data;
    logic             r_disp_overrun;

    logic w_io;
    logic w_sel_kbsr;
    logic w_sel_kbdr;
    logic w_sel_dsr;
    logic w_sel_ddr;
    logic w_sel_ram;
    logic w_kb_empty;
    logic w_push;
    logic w_pop;
    logic w_ddr_wr;
    logic w_ddr_accept;
    logic w_disp_fire;
    logic [ADDR_W-1:0] w_ram_idx;

    assign w_io       = (mar >= 16'hFE00);
    assign w_sel_kbsr = (mar == KBSR_ADDR);
    assign w_sel_kbdr = (mar == KBDR_ADDR);
    assign w_sel_dsr  = (mar == DSR_ADDR);
    assign w_sel_ddr  = (mar == DDR_ADDR);
    assign w_sel_ram  = ~w_io;
    assign w_ram_idx  = mar[ADDR_W-1:0];

    assign w_kb_empty = (r_kb_count == '0);
    assign kb_ready   = (r_kb_count != KB_FULL);
    assign w_push     = kb_valid & kb_ready;
    // No read strobe from the core: pop once mar has moved off KBDR.
    assign w_pop      = r_kbdr_q & ~w_sel_kbdr & ~w_kb_empty;

    assign w_ddr_wr     = memwe & w_sel_ddr;
    assign w_disp_fire  = r_disp_valid & disp_ready;
    assign w_ddr_accept = w_ddr_wr & (~r_disp_valid | disp_ready);

    assign disp_valid   = r_disp_valid;
    assign disp_data    = r_disp_data;
    assign disp_overrun = r_disp_overrun;

    always_comb begin
        memOut = 16'h0000;
        if (w_sel_kbsr) begin
            memOut = {~w_kb_empty, 15'b0};
        end else if (w_sel_kbdr) begin
            memOut = w_kb_empty ? 16'h0000 : {8'h00, r_kb_fifo[r_kb_rd_ptr]};
        end else if (w_sel_dsr) begin
            memOut = {~r_disp_valid, 15'b0};
        end else if (w_sel_ddr) begin
            memOut = {8'h00, r_disp_data};
        end else if (w_sel_ram) begin
            memOut = r_ram[w_ram_idx];
        end
    end

    // RAM is deliberately left out of reset so program images survive it.
    always_ff @(posedge clk) begin
        if (memwe && w_sel_ram) begin
            r_ram[w_ram_idx] <= mdr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_kb_fifo[r_kb_wr_ptr] <= kb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_kb_rd_ptr <= '0;
            r_kb_wr_ptr <= '0;
            r_kb_count  <= '0;
            r_kbdr_q    <= 1'b0;
        end else begin
            r_kbdr_q <= w_sel_kbdr;
            if (w_push) begin
                r_kb_wr_ptr <= r_kb_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_kb_rd_ptr <= r_kb_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_kb_count <= r_kb_count + CNT_W'(1);
                2'b01:   r_kb_count <= r_kb_count - CNT_W'(1);
                default: r_kb_count <= r_kb_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_valid   <= 1'b0;
            r_disp_data    <= 8'h00;
            r_disp_overrun <= 1'b0;
        end else begin
            if (w_ddr_accept) begin
                r_disp_valid <= 1'b1;
                r_disp_data  <= mdr[7:0];
            end else if (w_disp_fire) begin
                r_disp_valid <= 1'b0;
            end
            if (w_ddr_wr && !w_ddr_accept) begin
                r_disp_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: per-cycle vector table plus a
// hand-written reset-mid-operation sequence.
module tb_lc3_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic        memwe;
    logic [15:0] memOut;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready;
    logic        disp_overrun;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lc3_mem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .mar          (mar),
        .mdr          (mdr),
        .memwe        (memwe),
        .memOut       (memOut),
        .kb_valid     (kb_valid),
        .kb_data      (kb_data),
        .kb_ready     (kb_ready),
        .disp_valid   (disp_valid),
        .disp_data    (disp_data),
        .disp_ready   (disp_ready),
        .disp_overrun (disp_overrun)
    );

    // Inputs are applied just after a falling edge; expected outputs are the
    // values seen before the next rising edge.
    typedef struct {
        logic [15:0] mar;
        logic [15:0] mdr;
        logic        we;
        logic        kbv;
        logic [7:0]  kbd;
        logic        drdy;
        logic        chk_mem;
        logic [15:0] e_mem;
        logic        e_rdy;
        logic        e_dv;
        logic [7:0]  e_dd;
        logic        e_ovr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [15:0] m, input logic [15:0] d, input logic we,
                       input logic kbv, input logic [7:0] kbd, input logic drdy,
                       input logic cm, input logic [15:0] em, input logic er,
                       input logic edv, input logic [7:0] edd, input logic eo);
        vec_t v;
        v.mar = m; v.mdr = d; v.we = we; v.kbv = kbv; v.kbd = kbd; v.drdy = drdy;
        v.chk_mem = cm; v.e_mem = em; v.e_rdy = er; v.e_dv = edv; v.e_dd = edd;
        v.e_ovr = eo;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name, input logic er, input logic edv,
                                input logic [7:0] edd, input logic eo);
        check(name, {21'd0, kb_ready, disp_valid, disp_data, disp_overrun},
                    {21'd0, er, edv, edd, eo});
    endtask

    initial begin
        reset = 1'b1; mar = 16'hFE00; mdr = 16'h0000; memwe = 1'b0;
        kb_valid = 1'b0; kb_data = 8'h00; disp_ready = 1'b0;

        //   mar      mdr      we kbv kbd   drdy cm  e_mem    rdy dv dd     ovr
        // RAM write, read, alias, unmapped I/O
        add(16'h0010, 16'h1234, 1, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 8'h00, 0);
        add(16'h0010, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h1234, 1, 0, 8'h00, 0);
        add(16'h0110, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h1234, 1, 0, 8'h00, 0);
        add(16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 0);
        add(16'hFE08, 16'hFFFF, 1, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 0);
        add(16'hFE08, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 0);
        // keyboard order and single pop per KBDR dwell
        add(16'hFE00, 16'h0000, 0, 1, 8'h41, 0, 1, 16'h0000, 1, 0, 8'h00, 0);
        add(16'hFE00, 16'h0000, 0, 1, 8'h42, 0, 1, 16'h8000, 1, 0, 8'h00, 0);
        add(16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0041, 1, 0, 8'h00, 0);
        add(16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0041, 1, 0, 8'h00, 0);
        add(16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0041, 1, 0, 8'h00, 0);
        add(16'h3010, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h1234, 1, 0, 8'h00, 0);
        add(16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0042, 1, 0, 8'h00, 0);
        add(16'h3010, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h1234, 1, 0, 8'h00, 0);
        add(16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 0);
        add(16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 0);
        add(16'h3010, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h1234, 1, 0, 8'h00, 0);
        add(16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 0);
        // fill to full, 5th byte and pop-edge byte are dropped
        add(16'hFE00, 16'h0000, 0, 1, 8'h51, 0, 1, 16'h0000, 1, 0, 8'h00, 0);
        add(16'hFE00, 16'h0000, 0, 1, 8'h52, 0, 1, 16'h8000, 1, 0, 8'h00, 0);
        add(16'hFE00, 16'h0000, 0, 1, 8'h53, 0, 1, 16'h8000, 1, 0, 8'h00, 0);
        add(16'hFE00, 16'h0000, 0, 1, 8'h54, 0, 1, 16'h8000, 1, 0, 8'h00, 0);
        add(16'hFE00, 16'h0000, 0, 1, 8'h55, 0, 1, 16'h8000, 0, 0, 8'h00, 0);
        add(16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0051, 0, 0, 8'h00, 0);
        add(16'h3010, 16'h0000, 0, 1, 8'h56, 0, 1, 16'h1234, 0, 0, 8'h00, 0);
        add(16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0052, 1, 0, 8'h00, 0);
        // simultaneous push and pop at count 3
        add(16'h3010, 16'h0000, 0, 1, 8'h57, 0, 1, 16'h1234, 1, 0, 8'h00, 0);
        add(16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0053, 1, 0, 8'h00, 0);
        add(16'h3010, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h1234, 1, 0, 8'h00, 0);
        add(16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0054, 1, 0, 8'h00, 0);
        add(16'h3010, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h1234, 1, 0, 8'h00, 0);
        add(16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0057, 1, 0, 8'h00, 0);
        add(16'h3010, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h1234, 1, 0, 8'h00, 0);
        add(16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 0);
        // display accept and handshake
        add(16'hFE06, 16'h0058, 1, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 0);
        add(16'hFE04, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0000, 1, 1, 8'h58, 0);
        add(16'hFE04, 16'h0000, 0, 0, 8'h00, 1, 1, 16'h0000, 1, 1, 8'h58, 0);
        add(16'hFE04, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h8000, 1, 0, 8'h58, 0);
        // overrun, then write on a completing handshake edge
        add(16'hFE06, 16'h0041, 1, 0, 8'h00, 0, 1, 16'h0058, 1, 0, 8'h58, 0);
        add(16'hFE06, 16'h0042, 1, 0, 8'h00, 0, 1, 16'h0041, 1, 1, 8'h41, 0);
        add(16'hFE06, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0041, 1, 1, 8'h41, 1);
        add(16'hFE06, 16'h0043, 1, 0, 8'h00, 1, 1, 16'h0041, 1, 1, 8'h41, 1);
        add(16'hFE06, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0043, 1, 1, 8'h43, 1);
        add(16'hFE04, 16'hFFFF, 1, 0, 8'h00, 0, 1, 16'h0000, 1, 1, 8'h43, 1);
        add(16'hFE04, 16'h0000, 0, 0, 8'h00, 0, 1, 16'h0000, 1, 1, 8'h43, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("reset_kbsr", {16'd0, memOut}, 32'h0000);
        check_status("reset_status", 1'b1, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            mar = vecs[i].mar; mdr = vecs[i].mdr; memwe = vecs[i].we;
            kb_valid = vecs[i].kbv; kb_data = vecs[i].kbd; disp_ready = vecs[i].drdy;
            #2;
            if (vecs[i].chk_mem)
                check($sformatf("vec%0d_memOut", i), {16'd0, memOut}, {16'd0, vecs[i].e_mem});
            check_status($sformatf("vec%0d_status", i), vecs[i].e_rdy, vecs[i].e_dv,
                         vecs[i].e_dd, vecs[i].e_ovr);
        end

        // Reset mid-operation: FIFO holds two bytes, display byte pending.
        @(negedge clk);
        mar = 16'hFE00; memwe = 1'b0; disp_ready = 1'b0; kb_valid = 1'b1; kb_data = 8'h61;
        @(negedge clk);
        kb_data = 8'h62;
        @(negedge clk);
        kb_valid = 1'b0;
        #2;
        check("pre_reset_kbsr", {16'd0, memOut}, 32'h8000);
        reset = 1'b1; mar = 16'hFE06; mdr = 16'h0077; memwe = 1'b1;
        #2;
        check("in_reset_ddr_comb", {16'd0, memOut}, 32'h0043);
        @(negedge clk);
        reset = 1'b0; memwe = 1'b0; mar = 16'hFE00;
        #2;
        check("post_reset_kbsr", {16'd0, memOut}, 32'h0000);
        check_status("post_reset_status", 1'b1, 1'b0, 8'h00, 1'b0);
        mar = 16'hFE02;
        #1;
        check("post_reset_kbdr", {16'd0, memOut}, 32'h0000);
        mar = 16'hFE04;
        #1;
        check("post_reset_dsr", {16'd0, memOut}, 32'h8000);
        mar = 16'h0010;
        #1;
        check("post_reset_ram", {16'd0, memOut}, 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
